// File: rtl/dcnn_pkg.sv
// Shared constants, arbiter state encoding and helpers for the DCNN block-DMA path.
package dcnn_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned BLOCK_SIZE = 25;
    localparam int unsigned DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DELIVER = 2'd2,
        FINISH  = 2'd3
    } arb_state_t;

    // One-hot requester mask from a requester index.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
//   i_req        : request vector
//   i_last_owner : requester served most recently
//   o_winner_c   : chosen requester index (meaningful only when o_any_c)
//   o_any_c      : at least one request present
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_winner_c,
    output logic       o_any_c
);

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        o_any_c    = |i_req;
        o_winner_c = i_req[1];
        if (&i_req) begin
            o_winner_c = ~i_last_owner;
        end
    end

endmodule

// File: rtl/dma_block_arbiter.sv
// Shares the block-DMA read port between the image loader (0) and kernel loader (1).
// A grant covers a whole transfer of N consecutive BLOCK_SIZE-word blocks; one DMA
// handshake is issued per block and block-valid pulses are steered to the owner.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req                        : per-requester request level, sampled in IDLE only
//   req_addr0/1, req_blocks0/1 : transfer start address and block count per requester
//   gnt                        : one-hot owner, held for the whole transfer
//   blk_valid, blk_idx         : one-cycle pulse to owner with the 0-based block index
//   done                       : one-cycle pulse to owner at transfer end
//   dma_req, dma_addr, dma_ack : DMA read handshake
module dma_block_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BLOCK_SIZE = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [CNT_W-1:0]  req_blocks0,
    input  logic [CNT_W-1:0]  req_blocks1,
    output logic [1:0]        gnt,
    output logic [1:0]        blk_valid,
    output logic [CNT_W-1:0]  blk_idx,
    output logic [1:0]        done,
    output logic              dma_req,
    output logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_ack
);

    import dcnn_pkg::*;

    arb_state_t        r_state,      w_state_nxt;
    logic              r_last_owner, w_last_owner_nxt;
    logic              r_owner,      w_owner_nxt;
    logic [ADDR_W-1:0] r_cur_addr,   w_cur_addr_nxt;
    logic [CNT_W-1:0]  r_total,      w_total_nxt;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic [CNT_W-1:0]  r_blk_idx,    w_blk_idx_nxt;
    logic [1:0]        r_gnt,        w_gnt_nxt;
    logic [1:0]        r_blk_valid,  w_blk_valid_nxt;
    logic [1:0]        r_done,       w_done_nxt;
    logic              r_dma_req,    w_dma_req_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_winner;
    logic              w_any;

    rr_pick2 u_pick (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_winner_c   (w_winner),
        .o_any_c      (w_any)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_cur_addr   <= '0;
            r_total      <= '0;
            r_cnt        <= '0;
            r_blk_idx    <= '0;
            r_gnt        <= '0;
            r_blk_valid  <= '0;
            r_done       <= '0;
            r_dma_req    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_owner      <= w_owner_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_total      <= w_total_nxt;
            r_cnt        <= w_cnt_nxt;
            r_blk_idx    <= w_blk_idx_nxt;
            r_gnt        <= w_gnt_nxt;
            r_blk_valid  <= w_blk_valid_nxt;
            r_done       <= w_done_nxt;
            r_dma_req    <= w_dma_req_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_owner_nxt      = r_owner;
        w_cur_addr_nxt   = r_cur_addr;
        w_total_nxt      = r_total;
        w_cnt_nxt        = r_cnt;
        w_blk_idx_nxt    = r_blk_idx;
        w_gnt_nxt        = r_gnt;
        w_dma_req_nxt    = r_dma_req;
        w_blk_valid_nxt  = '0;
        w_done_nxt       = '0;
        w_cnt_inc        = r_cnt + CNT_W'(1);

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt    = w_winner;
                    w_gnt_nxt      = owner_onehot(w_winner);
                    w_cur_addr_nxt = w_winner ? req_addr1 : req_addr0;
                    w_total_nxt    = w_winner ? req_blocks1 : req_blocks0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = (w_total_nxt == '0) ? FINISH : ISSUE;
                end
            end

            // First cycle after grant only raises dma_req; later blocks arrive
            // here with dma_req already raised by DELIVER.
            ISSUE: begin
                if (!r_dma_req) begin
                    w_dma_req_nxt = 1'b1;
                end else if (dma_ack) begin
                    w_dma_req_nxt   = 1'b0;
                    w_blk_valid_nxt = owner_onehot(r_owner);
                    w_blk_idx_nxt   = r_cnt;
                    w_state_nxt     = DELIVER;
                end
            end

            // Exact compare on cnt+1 keeps a full-scale block count legal.
            DELIVER: begin
                w_cnt_nxt      = w_cnt_inc;
                w_cur_addr_nxt = r_cur_addr + ADDR_W'(BLOCK_SIZE);
                if (w_cnt_inc == r_total) begin
                    w_done_nxt  = owner_onehot(r_owner);
                    w_state_nxt = FINISH;
                end else begin
                    w_dma_req_nxt = 1'b1;
                    w_state_nxt   = ISSUE;
                end
            end

            // A zero-length grant arrives with done still low and raises it here.
            FINISH: begin
                if (r_done == '0) begin
                    w_done_nxt = owner_onehot(r_owner);
                end else begin
                    w_gnt_nxt        = '0;
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign blk_valid = r_blk_valid;
    assign blk_idx   = r_blk_idx;
    assign done      = r_done;
    assign dma_req   = r_dma_req;
    assign dma_addr  = r_cur_addr;

endmodule

// File: tb/tb_dma_block_arbiter.sv
// Self-checking bench for dma_block_arbiter: a transaction-level model predicts
// owner order, block addresses, block indices and grant length for each transfer.
module tb_dma_block_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned BS = 25;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [CW-1:0] req_blocks0, req_blocks1;
    logic [1:0]    gnt, blk_valid, done;
    logic [CW-1:0] blk_idx;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_ack;

    dma_block_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_blocks0 (req_blocks0),
        .req_blocks1 (req_blocks1),
        .gnt         (gnt),
        .blk_valid   (blk_valid),
        .blk_idx     (blk_idx),
        .done        (done),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_ack     (dma_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit m_last = 1'b1;

    // Observations of the most recent transfer.
    int            mon_owner, mon_gnt_cycles, mon_done, mon_wrong, mon_lat, mon_stab;
    int            mon_acks, mon_delay_sum, mon_first_req;
    bit            mon_timeout;
    logic [AW-1:0] mon_addr[$];
    int            mon_idx[$];

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] start, input int k);
        return AW'(int'(start) + k * int'(BS));
    endfunction

    function automatic int exp_winner(input logic [1:0] r);
        if (r == 2'b11) return m_last ? 0 : 1;
        return r[1] ? 1 : 0;
    endfunction

    // Expected grant length: one setup cycle, each block's request cycles plus
    // its deliver cycle, then the done cycle.
    function automatic int exp_gnt_cycles(input int nblk, input int dsum);
        return 2 + dsum + 2 * nblk;
    endfunction

    task automatic do_reset();
        req     = 2'b00;
        dma_ack = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
    endtask

    // Acts as DMA and observer for one transfer; caller sets req before the edge.
    task automatic run_txn(input int min_d, input int max_d, input bit drop,
                           input bit scramble, input bit spurious);
        int            owner;
        logic [1:0]    own_mask;
        int            held, cur_delay;
        bit            prev_ack, seen_done, finished;
        logic [AW-1:0] held_addr;
        owner = 0; own_mask = 2'b01; held = 0; prev_ack = 0; seen_done = 0; finished = 0;
        held_addr = '0;
        cur_delay = int'($urandom_range(max_d, min_d));
        mon_owner = -1; mon_gnt_cycles = 0; mon_done = 0; mon_wrong = 0; mon_lat = 0;
        mon_stab = 0; mon_acks = 0; mon_delay_sum = 0; mon_first_req = -1; mon_timeout = 0;
        mon_addr.delete();
        mon_idx.delete();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (gnt == 2'b01) owner = 0;
                else if (gnt == 2'b10) owner = 1;
                else break;
                own_mask  = (owner == 1) ? 2'b10 : 2'b01;
                mon_owner = owner;
            end
            if (gnt == 2'b00) begin
                finished = 1;
                break;
            end
            mon_gnt_cycles++;
            if (((gnt | blk_valid | done) & ~own_mask) != 2'b00) mon_wrong++;
            if (dma_req && mon_first_req < 0) mon_first_req = c;
            if ((blk_valid != 2'b00) != prev_ack) mon_lat++;
            if ((blk_valid & own_mask) != 2'b00) mon_idx.push_back(int'(blk_idx));
            if ((done & own_mask) != 2'b00) begin
                mon_done++;
                seen_done = 1;
                if (drop) begin
                    if (owner == 1) req[1] = 1'b0;
                    else req[0] = 1'b0;
                end
            end
            if (scramble && c == 2) begin
                req_addr0   = AW'($urandom);
                req_addr1   = AW'($urandom);
                req_blocks0 = CW'($urandom_range(4, 0));
                req_blocks1 = CW'($urandom_range(4, 0));
            end
            prev_ack = 0;
            if (dma_req) begin
                if (held == 0) begin
                    held_addr = dma_addr;
                    mon_addr.push_back(dma_addr);
                end else if (dma_addr !== held_addr) begin
                    mon_stab++;
                end
                if (held == cur_delay) begin
                    dma_ack = 1'b1;
                    prev_ack = 1;
                    mon_acks++;
                    mon_delay_sum += cur_delay;
                    held = 0;
                    cur_delay = int'($urandom_range(max_d, min_d));
                end else begin
                    dma_ack = 1'b0;
                    held++;
                end
            end else begin
                held = 0;
                dma_ack = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end
        dma_ack = 1'b0;
        if (!finished) mon_timeout = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, dma_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt_req got gnt=%b dma_req=%b want 00/0", gnt, dma_req);
        end
        checks++;
        if ({blk_valid, done, dma_addr, blk_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got blk_valid=%b done=%b addr=%h idx=%0d want all 0",
                     blk_valid, done, dma_addr, blk_idx);
        end
    endtask

    task automatic test_single();
        logic [AW-1:0] want[3];
        want[0] = 16'h0100; want[1] = 16'h0119; want[2] = 16'h0132;
        req_addr0 = 16'h0100; req_blocks0 = 16'd3;
        req_addr1 = AW'($urandom); req_blocks1 = 16'd2;
        req = 2'b01;
        run_txn(1, 1, 1, 0, 0);
        checks++;
        if (mon_timeout || mon_owner != 0) begin
            errors++;
            $display("FAIL single_owner got %0d (timeout=%0d) want 0", mon_owner, mon_timeout);
        end
        checks++;
        if (mon_addr.size() != 3) begin
            errors++;
            $display("FAIL single_addr_count got %0d want 3", mon_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_addr[i] !== want[i]) begin
                    errors++;
                    $display("FAIL single_addr[%0d] got %h want %h", i, mon_addr[i], want[i]);
                end
            end
        end
        checks++;
        if (mon_idx.size() != 3 || mon_idx[0] != 0 || mon_idx[1] != 1 || mon_idx[2] != 2) begin
            errors++;
            $display("FAIL single_blk_idx got count %0d want 0,1,2", mon_idx.size());
        end
        checks++;
        if (mon_done != 1 || mon_wrong != 0) begin
            errors++;
            $display("FAIL single_done got done=%0d stray=%0d want 1/0", mon_done, mon_wrong);
        end
        checks++;
        if (mon_first_req != 1) begin
            errors++;
            $display("FAIL single_gnt_to_req got %0d want 1", mon_first_req);
        end
        checks++;
        if (mon_gnt_cycles != exp_gnt_cycles(3, mon_delay_sum) || mon_lat != 0) begin
            errors++;
            $display("FAIL single_timing got gnt_cycles=%0d lat_err=%0d want %0d/0",
                     mon_gnt_cycles, mon_lat, exp_gnt_cycles(3, mon_delay_sum));
        end
        m_last = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_addr0 = 16'h1000; req_blocks0 = 16'd2;
        req_addr1 = 16'h2000; req_blocks1 = 16'd2;
        req = 2'b11;
        run_txn(0, 2, 1, 0, 0);
        checks++;
        if (mon_timeout || mon_owner != exp_winner(2'b11) || mon_done != 1) begin
            errors++;
            $display("FAIL simul_first got owner=%0d done=%0d want %0d/1",
                     mon_owner, mon_done, exp_winner(2'b11));
        end
        m_last = 1'b0;
        run_txn(0, 2, 1, 0, 0);
        checks++;
        if (mon_timeout || mon_owner != 1 || mon_done != 1) begin
            errors++;
            $display("FAIL simul_second got owner=%0d done=%0d want 1/1", mon_owner, mon_done);
        end
        checks++;
        if (mon_addr.size() != 2 || mon_addr[0] !== 16'h2000 || mon_addr[1] !== 16'h2019) begin
            errors++;
            $display("FAIL simul_second_addr got count %0d want 2000,2019", mon_addr.size());
        end
        m_last = 1'b1;
    endtask

    task automatic test_fairness();
        int w;
        for (int i = 0; i < 4; i++) begin
            req_addr0 = AW'($urandom); req_blocks0 = CW'($urandom_range(3, 1));
            req_addr1 = AW'($urandom); req_blocks1 = CW'($urandom_range(3, 1));
            req = 2'b11;
            w = exp_winner(2'b11);
            run_txn(0, 2, 1, 0, 0);
            checks++;
            if (mon_timeout || mon_owner != w || mon_done != 1) begin
                errors++;
                $display("FAIL fair_owner[%0d] got owner=%0d done=%0d want %0d/1",
                         i, mon_owner, mon_done, w);
            end
            m_last = (w == 1);
        end
        req = 2'b00;
    endtask

    task automatic test_zero_length();
        req_addr1 = AW'($urandom); req_blocks1 = 16'd0;
        req = 2'b10;
        run_txn(0, 0, 1, 0, 0);
        checks++;
        if (mon_timeout || mon_owner != 1 || mon_gnt_cycles != 2 || mon_done != 1) begin
            errors++;
            $display("FAIL zero_len got owner=%0d gnt_cycles=%0d done=%0d want 1/2/1",
                     mon_owner, mon_gnt_cycles, mon_done);
        end
        checks++;
        if (mon_addr.size() != 0 || mon_idx.size() != 0) begin
            errors++;
            $display("FAIL zero_len_dma got reqs=%0d blk_valids=%0d want 0/0",
                     mon_addr.size(), mon_idx.size());
        end
        m_last = 1'b1;
    endtask

    task automatic test_slow_dma();
        logic [AW-1:0] a;
        a = AW'($urandom);
        req_addr0 = a; req_blocks0 = 16'd2;
        req = 2'b01;
        run_txn(5, 5, 1, 0, 1);
        checks++;
        if (mon_timeout || mon_stab != 0 || mon_lat != 0) begin
            errors++;
            $display("FAIL slow_stable got stab_err=%0d lat_err=%0d timeout=%0d want 0",
                     mon_stab, mon_lat, mon_timeout);
        end
        checks++;
        if (mon_acks != 2 || mon_idx.size() != 2 || mon_gnt_cycles != 16) begin
            errors++;
            $display("FAIL slow_count got acks=%0d blk_valids=%0d gnt_cycles=%0d want 2/2/16",
                     mon_acks, mon_idx.size(), mon_gnt_cycles);
        end
        checks++;
        if (mon_addr.size() != 2 || mon_addr[1] !== exp_addr(a, 1)) begin
            errors++;
            $display("FAIL slow_addr got count %0d want second %h", mon_addr.size(), exp_addr(a, 1));
        end
        m_last = 1'b0;
    endtask

    task automatic test_addr_wrap();
        req_addr0 = 16'hFFF0; req_blocks0 = 16'd2;
        req = 2'b01;
        run_txn(0, 1, 1, 0, 0);
        checks++;
        if (mon_addr.size() != 2 || mon_addr[0] !== 16'hFFF0 || mon_addr[1] !== 16'h0009) begin
            errors++;
            $display("FAIL addr_wrap got count %0d want FFF0,0009", mon_addr.size());
        end
        m_last = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]    r;
        int            w, n;
        logic [AW-1:0] start;
        for (int t = 0; t < 10; t++) begin
            r = 2'($urandom_range(3, 1));
            req_addr0 = AW'($urandom); req_blocks0 = CW'($urandom_range(4, 0));
            req_addr1 = AW'($urandom); req_blocks1 = CW'($urandom_range(4, 0));
            w     = exp_winner(r);
            start = (w == 1) ? req_addr1 : req_addr0;
            n     = (w == 1) ? int'(req_blocks1) : int'(req_blocks0);
            req   = r;
            run_txn(0, 3, 1, 1, 1);
            checks++;
            if (mon_timeout || mon_owner != w || mon_done != 1 || mon_wrong != 0) begin
                errors++;
                $display("FAIL rand[%0d]_owner got owner=%0d done=%0d stray=%0d want %0d/1/0",
                         t, mon_owner, mon_done, mon_wrong, w);
            end
            checks++;
            if (mon_addr.size() != n || mon_idx.size() != n) begin
                errors++;
                $display("FAIL rand[%0d]_count got reqs=%0d blk_valids=%0d want %0d",
                         t, mon_addr.size(), mon_idx.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (mon_addr[k] !== exp_addr(start, k) || mon_idx[k] != k) begin
                        errors++;
                        $display("FAIL rand[%0d]_blk[%0d] got addr=%h idx=%0d want %h/%0d",
                                 t, k, mon_addr[k], mon_idx[k], exp_addr(start, k), k);
                    end
                end
            end
            checks++;
            if (mon_gnt_cycles != exp_gnt_cycles(n, mon_delay_sum) || mon_lat != 0 || mon_stab != 0) begin
                errors++;
                $display("FAIL rand[%0d]_timing got gnt_cycles=%0d lat=%0d stab=%0d want %0d/0/0",
                         t, mon_gnt_cycles, mon_lat, mon_stab, exp_gnt_cycles(n, mon_delay_sum));
            end
            m_last = (w == 1);
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid();
        int  stray;
        bit  got_req;
        got_req = 0;
        stray   = 0;
        req = 2'b00;
        @(negedge clk);
        req_addr0 = AW'($urandom); req_blocks0 = 16'd4;
        req = 2'b01;
        dma_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dma_req) begin
                got_req = 1;
                break;
            end
        end
        checks++;
        if (!got_req) begin
            errors++;
            $display("FAIL rst_mid_wait got no dma_req within 10 cycles want dma_req=1");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, blk_valid, done, dma_req} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got gnt=%b blk_valid=%b done=%b dma_req=%b want 0",
                     gnt, blk_valid, done, dma_req);
        end
        checks++;
        if ({dma_addr, blk_idx} !== '0) begin
            errors++;
            $display("FAIL rst_mid_data got addr=%h idx=%0d want 0/0", dma_addr, blk_idx);
        end
        rst_n  = 1'b1;
        req    = 2'b00;
        m_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({gnt, done, dma_req} != 5'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got %0d active cycles want 0", stray);
        end
        req_blocks0 = 16'd1; req_blocks1 = 16'd1;
        req = 2'b11;
        run_txn(0, 1, 1, 0, 0);
        checks++;
        if (mon_timeout || mon_owner != exp_winner(2'b11)) begin
            errors++;
            $display("FAIL rst_mid_tie got owner=%0d want %0d", mon_owner, exp_winner(2'b11));
        end
        req = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; dma_ack = 1'b0;
        req_addr0 = '0; req_addr1 = '0; req_blocks0 = '0; req_blocks1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_zero_length();
        test_slow_dma();
        test_addr_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion within time limit want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
